// File: rtl/fill_score_tracker.sv
// fill_score_tracker: per-frame shaded-pixel percentage via a restoring divider, with a sticky win flag.
// Define WIN_CONFIRM_EN to require two consecutive qualifying frames before game_win asserts.
module fill_score_tracker #(
  parameter int FIELD_PIXELS = 786432,
  parameter int CNT_W        = 20,
  parameter int WIN_PERCENT  = 75
) (
  input  logic       clk_65M,
  input  logic       clear,
  input  logic       frame_start,
  input  logic       pix_valid,
  input  logic       pix_shaded,
  input  logic       game_on,
  output logic [6:0] score,
  output logic       score_valid,
  output logic       busy,
  output logic       game_win,
  output logic       frame_overrun
);
  localparam int DW = 27;
  localparam int RW = $clog2(FIELD_PIXELS + 1) + 1;
  localparam logic [RW-1:0] DIV = RW'(FIELD_PIXELS);
  typedef enum logic [1:0] {ACCUM, DIVIDE, UPDATE} state_t;
  state_t          state_q;
  logic [CNT_W-1:0] cnt_q, snap_q;
  logic [DW-1:0]   dvd, quot_q, quot_d;
  logic [RW-2:0]   rem_q;
  logic [RW-1:0]   rem_sh;
  logic [4:0]      idx_q;
  logic [6:0]      score_d;
  logic            hit, ge, qual;
`ifdef WIN_CONFIRM_EN
  logic            pend_q;
`endif
  assign hit = pix_valid & pix_shaded;
  // snapshot stays frozen while dividing, so the dividend needs no register
  assign dvd = (DW'(snap_q) << 6) + (DW'(snap_q) << 5) + (DW'(snap_q) << 2);
  assign rem_sh = {rem_q, dvd[idx_q]};
  assign ge = rem_sh >= DIV;
  assign quot_d = quot_q | (DW'(ge) << idx_q);
  assign score_d = quot_d > DW'(100) ? 7'd100 : quot_d[6:0];
  assign qual = game_on && score >= 7'(WIN_PERCENT);
  always_ff @(posedge clk_65M or posedge clear) begin
    if (clear) begin
      state_q       <= ACCUM;
      cnt_q         <= '0;
      snap_q        <= '0;
      quot_q        <= '0;
      rem_q         <= '0;
      idx_q         <= '0;
      score         <= '0;
      score_valid   <= 1'b0;
      busy          <= 1'b0;
      game_win      <= 1'b0;
      frame_overrun <= 1'b0;
`ifdef WIN_CONFIRM_EN
      pend_q        <= 1'b0;
`endif
    end else begin
      score_valid <= 1'b0;
      if (frame_start) cnt_q <= CNT_W'(hit);
      else if (hit && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
      if (frame_start && state_q != ACCUM) frame_overrun <= 1'b1;
      case (state_q)
        ACCUM: if (frame_start) begin
          snap_q  <= cnt_q;
          quot_q  <= '0;
          rem_q   <= '0;
          idx_q   <= 5'd26;
          busy    <= 1'b1;
          state_q <= DIVIDE;
        end
        DIVIDE: begin
          rem_q  <= ge ? (RW-1)'(rem_sh - DIV) : rem_sh[RW-2:0];
          quot_q <= quot_d;
          idx_q  <= idx_q - 1'b1;
          if (idx_q == 5'd0) begin
            score       <= score_d;
            score_valid <= 1'b1;
            busy        <= 1'b0;
            state_q     <= UPDATE;
          end
        end
        default: begin
`ifdef WIN_CONFIRM_EN
          pend_q <= qual;
          if (qual && pend_q) game_win <= 1'b1;
`else
          if (qual) game_win <= 1'b1;
`endif
          state_q <= ACCUM;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fill_score_tracker.sv
// tb_fill_score_tracker: directed checks on a 3072-pixel field with a 12-bit counter.
module tb_fill_score_tracker;
  logic clk = 1'b0, clear = 1'b1, fs = 1'b0, pv = 1'b0, ps = 1'b0, game_on = 1'b0;
  logic [6:0] score;
  logic score_valid, busy, game_win, frame_overrun;
  int checks = 0, errors = 0;

  fill_score_tracker #(.FIELD_PIXELS(3072), .CNT_W(12), .WIN_PERCENT(75)) dut (
    .clk_65M(clk), .clear(clear), .frame_start(fs), .pix_valid(pv), .pix_shaded(ps),
    .game_on(game_on), .score(score), .score_valid(score_valid), .busy(busy),
    .game_win(game_win), .frame_overrun(frame_overrun));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic stream(input int n);
    for (int i = 0; i < n; i++) begin pv = 1; ps = 1; tick(); end
    pv = 1; ps = 0; repeat (50) tick();
    pv = 0; ps = 1; repeat (50) tick();
    ps = 0;
  endtask

  task automatic run_frame(input logic [6:0] es, input logic ew, input string nm);
    int lat;
    fs = 1; tick(); fs = 0; lat = 1;
    while (!score_valid && lat < 40) begin tick(); lat++; end
    checks++; if (lat !== 28) begin errors++; $display("FAIL %s latency: got %0d want 28", nm, lat); end
    checks++; if (score !== es) begin errors++; $display("FAIL %s score: got %0d want %0d", nm, score, es); end
    tick();
    checks++; if (score_valid !== 1'b0) begin errors++; $display("FAIL %s valid_pulse: got %b want 0", nm, score_valid); end
    checks++; if (game_win !== ew) begin errors++; $display("FAIL %s game_win: got %b want %b", nm, game_win, ew); end
  endtask

  task automatic test_reset();
    repeat (2) tick();
    checks++; if (score !== 7'd0) begin errors++; $display("FAIL reset score: got %0d want 0", score); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
    checks++; if (score_valid !== 1'b0) begin errors++; $display("FAIL reset score_valid: got %b want 0", score_valid); end
    checks++; if (game_win !== 1'b0) begin errors++; $display("FAIL reset game_win: got %b want 0", game_win); end
    checks++; if (frame_overrun !== 1'b0) begin errors++; $display("FAIL reset frame_overrun: got %b want 0", frame_overrun); end
    clear = 0; tick();
  endtask

  task automatic test_half();
    stream(1536);
    run_frame(7'd50, 1'b0, "half");
  endtask

  task automatic test_reset_mid_divide();
    int seen = 0;
    stream(1536);
    fs = 1; tick(); fs = 0;
    repeat (10) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL middiv busy_before: got %b want 1", busy); end
    clear = 1; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL middiv busy: got %b want 0", busy); end
    checks++; if (score !== 7'd0) begin errors++; $display("FAIL middiv score: got %0d want 0", score); end
    tick(); clear = 0;
    for (int i = 0; i < 40; i++) begin tick(); if (score_valid) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL middiv no_pulse: got %0d pulses want 0", seen); end
  endtask

  task automatic test_floor();
    game_on = 1;
    stream(2303);
    run_frame(7'd74, 1'b0, "floor");
  endtask

  task automatic test_game_off();
    game_on = 0;
    stream(2303);
    run_frame(7'd74, 1'b0, "off_floor");
    stream(3072);
    run_frame(7'd100, 1'b0, "off_full");
  endtask

  task automatic test_win();
    game_on = 1;
    stream(2304);
`ifdef WIN_CONFIRM_EN
    run_frame(7'd75, 1'b0, "win_first");
    stream(2304);
    run_frame(7'd75, 1'b1, "win_second");
`else
    run_frame(7'd75, 1'b1, "win");
`endif
    game_on = 0;
    stream(1536);
    run_frame(7'd50, 1'b1, "win_sticky");
  endtask

  task automatic test_overrun();
    int k = 0;
    checks++; if (frame_overrun !== 1'b0) begin errors++; $display("FAIL ovr before: got %b want 0", frame_overrun); end
    stream(1536);
    pv = 1; ps = 1; fs = 1; tick(); fs = 0;
    repeat (9) tick();
    checks++; if (dut.cnt_q !== 12'd10) begin errors++; $display("FAIL ovr counter_start: got %0d want 10", dut.cnt_q); end
    fs = 1; tick(); fs = 0; pv = 0; ps = 0;
    checks++; if (frame_overrun !== 1'b1) begin errors++; $display("FAIL ovr flag: got %b want 1", frame_overrun); end
    while (!score_valid && k < 40) begin tick(); k++; end
    checks++; if (score_valid !== 1'b1) begin errors++; $display("FAIL ovr timeout: got %b want 1", score_valid); end
    checks++; if (score !== 7'd50) begin errors++; $display("FAIL ovr score: got %0d want 50", score); end
    tick();
    stream(1535);
    run_frame(7'd50, 1'b1, "ovr_next");
    checks++; if (frame_overrun !== 1'b1) begin errors++; $display("FAIL ovr sticky: got %b want 1", frame_overrun); end
  endtask

  task automatic test_saturate();
    stream(3200);
    run_frame(7'd100, 1'b1, "over_field");
    pv = 1; ps = 1; repeat (4101) tick(); pv = 0; ps = 0;
    checks++; if (dut.cnt_q !== 12'hFFF) begin errors++; $display("FAIL sat counter: got %0d want 4095", dut.cnt_q); end
    run_frame(7'd100, 1'b1, "saturate");
  endtask

  initial begin
    test_reset();
    test_half();
    test_reset_mid_divide();
    test_floor();
    test_game_off();
    test_win();
    test_overrun();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fill_score_tracker.md
Name: fill_score_tracker

Overview:
- Sits downstream of the playfield BRAM read and VGA scan path.
- Counts shaded pixels streamed during each visible frame and converts the count to a 0..100 percentage using a sequential restoring divider.
- Drives `score` into the BCD converter and asserts `game_win` to the game controller once the shaded share reaches the win threshold.

Parameters:
- FIELD_PIXELS, 786432, number of playfield pixels per frame (1024x768); divisor.
- CNT_W, 20, width of the pixel counter; must hold FIELD_PIXELS.
- WIN_PERCENT, 75, score at or above which `game_win` asserts.

Ports:
- clk_65M  input  1  pixel clock; all logic on rising edge.
- clear  input  1  asynchronous active-high reset.
- frame_start  input  1  one-cycle pulse at the first pixel of a frame (h_count=0, v_count=0).
- pix_valid  input  1  current pixel is inside the playfield and vid_on is high.
- pix_shaded  input  1  current pixel is claimed/shaded; qualified by pix_valid.
- game_on  input  1  game running; gates `game_win`.
- score  output  7  latest frame percentage, 0..100.
- score_valid  output  1  one-cycle pulse when `score` updates.
- busy  output  1  divider active.
- game_win  output  1  sticky win flag.
- frame_overrun  output  1  sticky: frame_start arrived while busy.

Behaviour:
- Reset (clear=1, asynchronous): pixel counter=0, snapshot=0, quotient=0, score=0, score_valid=0, busy=0, game_win=0, frame_overrun=0, state=ACCUM.
- Counter:
  - Increments by 1 on each cycle with pix_valid & pix_shaded.
  - Saturates at 2^CNT_W-1; no wrap.
- frame_start cycle:
  - Snapshot := counter value (pixels of the completed frame).
  - Counter := 1 if pix_valid & pix_shaded in that same cycle, else 0.
  - Snapshot and counter reset are simultaneous; no pixel is lost or double counted.
- States:
  - ACCUM (busy=0): frame_start -> DIVIDE. Dividend := snapshot*100 (27 bits, computed as (s<<6)+(s<<5)+(s<<2)). Remainder := 0. Iteration index := 26.
  - DIVIDE (busy=1): one restoring step per cycle, MSB first, 27 cycles. When index reaches 0 -> UPDATE.
  - UPDATE (busy=0): score := min(quotient, 100), 7-bit. score_valid=1 for exactly this cycle. Win evaluation happens here. Next state is ACCUM.
- Latency: frame_start at cycle T -> score/score_valid at cycle T+28.
- frame_start while in DIVIDE or UPDATE:
  - The counter still resets, so the new frame starts counting.
  - The snapshot is discarded; the divider is not restarted.
  - frame_overrun := 1, sticky until clear.
- Rounding: floor. Snapshot > FIELD_PIXELS saturates score at 100.
- Win: in UPDATE, if game_on=1 and the new score >= WIN_PERCENT, game_win := 1. game_win stays 1 until clear; game_on=0 does not clear it.
- score holds its value between updates. There is no output for a partial frame.

Optional Feature:
- Macro: WIN_CONFIRM_EN.
- With the macro defined:
  - game_win requires two consecutive UPDATE results >= WIN_PERCENT with game_on=1.
  - A 1-bit pending flag sets on the first qualifying result and clears on any non-qualifying result.
  - An overrun frame, which has no UPDATE, leaves the flag unchanged.
  - clear resets the flag.
- Without the macro: a single qualifying UPDATE sets game_win and no pending flag exists.

Test Plan:
- Reset mid-DIVIDE: assert clear 10 cycles after frame_start -> busy=0 and score=0 immediately; no score_valid pulse follows.
- 393216 shaded pixels in a frame, then frame_start -> at T+28 score=50, one-cycle score_valid, game_win=0.
- 589824 shaded pixels with game_on=1 -> score=75 and game_win=1. With WIN_CONFIRM_EN: game_win=0 after frame 1 and 1 after an identical frame 2.
- 589823 shaded pixels -> score=74 (floor), game_win=0. Same count with game_on=0 -> score=74 and game_win stays 0 even for 786432.
- Shaded pixel in the frame_start cycle, plus a second frame_start 10 cycles later -> the new frame's counter begins at 1, frame_overrun=1, and the score reflects the first frame only.
- Force snapshot 800000 (above FIELD_PIXELS) -> score=100. Hold pix_shaded for 2^20+5 cycles -> counter saturates at 1048575.
